dec_stage: RTL and testbench
============================

DEC_STAGE -- requirements
Module: dec_stage

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with ports named Clk and Rst.
REQ-002 Parameter BYPASS_EN, default 1, SHALL enable write-back-to-operand bypass; when 0, operands come only from the register file.
REQ-003 Clk  in  1  rising-edge clock shared with the register file.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 Instr  in  32  MIPS instruction word from fetch.
REQ-006 InstrValid  in  1  Instr is valid.
REQ-007 InstrReady  out  1  stage can accept Instr.
REQ-008 RfArd1, RfArd2  out  5 each  register-file read addresses.
REQ-009 RfDout1, RfDout2  in  32 each  register-file read data, combinational from the addresses.
REQ-010 WbAwr  in  5, WbDin  in  32, WbWrEn  in  1  write-back bus, the same signals that drive the register-file write port.
REQ-011 OpA, OpB, Imm  out  32 each  latched operands and extended immediate.
REQ-012 DstReg  out  5, Opcode  out  6, Func  out  6  latched decode fields.
REQ-013 OutValid  out  1, OutReady  in  1  downstream handshake.

Function
REQ-014 The FSM SHALL have three states, IDLE, READ and FULL, and a 32-bit instruction register IR.
REQ-015 In IDLE:
- InstrReady=1 and OutValid=0.
- On InstrValid=1, IR<=Instr and the next state is READ.
REQ-016 In READ:
- InstrReady=0 and OutValid=0.
- At the edge, OpA, OpB, Imm, DstReg, Opcode and Func SHALL be latched.
- The next state is FULL.
REQ-017 RfArd1 SHALL equal IR[25:21] and RfArd2 SHALL equal IR[20:16] in all states.
REQ-018 Operand select for OpA (OpB identical using RfArd2/RfDout2):
- If RfArd1=0, then 0.
- Else if BYPASS_EN and WbWrEn and WbAwr==RfArd1, then WbDin.
- Else RfDout1.
REQ-019 While in FULL and not handshaking, a write-back matching a held nonzero source address SHALL update the held OpA/OpB at that edge (BYPASS_EN=1 only).
REQ-020 DstReg selection:
- IR[15:11] when Opcode=0.
- 31 when Opcode=6'h03 (jal).
- IR[20:16] otherwise.
REQ-021 Imm selection:
- Zero-extended IR[15:0] for opcodes 0x0C, 0x0D and 0x0E.
- {IR[15:0],16'h0} for 0x0F.
- Sign-extended IR[15:0] otherwise.
REQ-022 In FULL:
- OutValid=1 and InstrReady=OutReady.
- If OutReady=1 and InstrValid=1, IR<=Instr and the next state is READ.
- If OutReady=1 and InstrValid=0, the next state is IDLE.
- If OutReady=0, outputs SHALL hold stable and the state remains FULL.
REQ-023 Latency SHALL be: instruction accepted at edge N gives OutValid=1 after edge N+1; sustained throughput SHALL be one instruction per 2 cycles.
REQ-024 Opcode=IR[31:26] and Func=IR[5:0] SHALL be latched in READ; Func is latched regardless of opcode.

Reset
REQ-025 When Rst=1 at a rising edge:
- State becomes IDLE.
- IR, OpA, OpB, Imm, DstReg, Opcode and Func all become 0.
REQ-026 While Rst=1, InstrReady=0 and OutValid=0.
REQ-027 Reset asserted mid-operation (READ or FULL) SHALL discard the in-flight instruction; no OutValid pulse SHALL follow.

Verification
REQ-028 Scenario, R-type add:
- Stimulus: reg 8=5, reg 9=7; Instr=0x01095020 (add $10,$8,$9).
- Required: OutValid two edges after accept with OpA=5, OpB=7, DstReg=10, Opcode=0, Func=0x20.
REQ-029 Scenario, immediate extension:
- Stimulus: ori $4,$0,0x8001 (0x34048001).
- Required: Imm=0x00008001, OpA=0, DstReg=4.
- Stimulus: addi with imm 0x8001.
- Required: Imm=0xFFFF8001.
REQ-030 Scenario, READ-cycle bypass:
- Stimulus: WbWrEn=1, WbAwr=8, WbDin=0xDEADBEEF in the READ cycle, register file still returning old reg 8.
- Required: OpA=0xDEADBEEF.
- Stimulus: same with WbAwr=0.
- Required: OpA=0.
REQ-031 Scenario, stall:
- Stimulus: OutReady=0 for 5 cycles in FULL, with a write to reg 9 in cycle 3.
- Required: OutValid stays 1, only OpB updates, InstrReady=0; on OutReady=1 the handshake completes.
REQ-032 Scenario, back-to-back:
- Stimulus: InstrValid held high, OutReady=1.
- Required: OutValid pulses every second cycle with instructions in order.
REQ-033 Scenario, reset mid-operation:
- Stimulus: Rst=1 for one edge while in READ.
- Required: next cycle all outputs are 0, InstrReady=1, and no OutValid until a new instruction is accepted.

Source files
------------

// File: rtl/dec_stage.sv
// rtl/dec_stage.sv - MIPS decode stage: operand fetch with write-back bypass and ready/valid handshakes
module dec_stage #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Instr,
    input  logic        InstrValid,
    output logic        InstrReady,
    output logic [4:0]  RfArd1,
    output logic [4:0]  RfArd2,
    input  logic [31:0] RfDout1,
    input  logic [31:0] RfDout2,
    input  logic [4:0]  WbAwr,
    input  logic [31:0] WbDin,
    input  logic        WbWrEn,
    output logic [31:0] OpA,
    output logic [31:0] OpB,
    output logic [31:0] Imm,
    output logic [4:0]  DstReg,
    output logic [5:0]  Opcode,
    output logic [5:0]  Func,
    output logic        OutValid,
    input  logic        OutReady
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic        accept;
    logic        hit_a;
    logic        hit_b;
    logic [31:0] op_a_sel;
    logic [31:0] op_b_sel;
    logic [31:0] imm_sel;
    logic [4:0]  dst_sel;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (InstrValid) state_next = READ;
            READ: state_next = FULL;
            FULL: begin
                if (OutReady) begin
                    state_next = InstrValid ? READ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        InstrReady = 1'b0;
        OutValid   = 1'b0;
        if (!Rst) begin
            case (state)
                IDLE: InstrReady = 1'b1;
                FULL: begin
                    OutValid   = 1'b1;
                    InstrReady = OutReady;
                end
                default: begin
                    InstrReady = 1'b0;
                    OutValid   = 1'b0;
                end
            endcase
        end
    end

    assign accept = InstrReady && InstrValid;

    // IR is only replaced on accept, so these remain the held source addresses while FULL
    assign RfArd1 = ir[25:21];
    assign RfArd2 = ir[20:16];

    assign hit_a = BYPASS_EN && WbWrEn && (WbAwr == RfArd1) && (RfArd1 != 5'd0);
    assign hit_b = BYPASS_EN && WbWrEn && (WbAwr == RfArd2) && (RfArd2 != 5'd0);

    assign op_a_sel = (RfArd1 == 5'd0) ? 32'd0 : (hit_a ? WbDin : RfDout1);
    assign op_b_sel = (RfArd2 == 5'd0) ? 32'd0 : (hit_b ? WbDin : RfDout2);

    always_comb begin
        case (ir[31:26])
            6'h0C, 6'h0D, 6'h0E: imm_sel = {16'h0000, ir[15:0]};
            6'h0F:               imm_sel = {ir[15:0], 16'h0000};
            default:             imm_sel = {{16{ir[15]}}, ir[15:0]};
        endcase
    end

    always_comb begin
        case (ir[31:26])
            6'h00:   dst_sel = ir[15:11];
            6'h03:   dst_sel = 5'd31;
            default: dst_sel = ir[20:16];
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ir     <= 32'd0;
            OpA    <= 32'd0;
            OpB    <= 32'd0;
            Imm    <= 32'd0;
            DstReg <= 5'd0;
            Opcode <= 6'd0;
            Func   <= 6'd0;
        end else begin
            if (accept) begin
                ir <= Instr;
            end
            if (state == READ) begin
                OpA    <= op_a_sel;
                OpB    <= op_b_sel;
                Imm    <= imm_sel;
                DstReg <= dst_sel;
                Opcode <= ir[31:26];
                Func   <= ir[5:0];
            end else if (state == FULL && !OutReady) begin
                // A stalled result must not go stale behind a later write-back
                if (hit_a) OpA <= WbDin;
                if (hit_b) OpB <= WbDin;
            end
        end
    end

endmodule

// File: tb/tb_dec_stage.sv
// tb/tb_dec_stage.sv - self-checking bench for dec_stage with a behavioural register-file and decode model
module tb_dec_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Instr;
    logic        InstrValid;
    logic        InstrReady;
    logic [4:0]  RfArd1, RfArd2;
    logic [31:0] RfDout1, RfDout2;
    logic [4:0]  WbAwr;
    logic [31:0] WbDin;
    logic        WbWrEn;
    logic [31:0] OpA, OpB, Imm;
    logic [4:0]  DstReg;
    logic [5:0]  Opcode, Func;
    logic        OutValid;
    logic        OutReady;

    int checks = 0;
    int failures = 0;

    logic [31:0] rf [32];

    always #5 Clk = ~Clk;

    dec_stage #(.BYPASS_EN(1'b1)) dut (
        .Clk(Clk), .Rst(Rst), .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .RfArd1(RfArd1), .RfArd2(RfArd2), .RfDout1(RfDout1), .RfDout2(RfDout2),
        .WbAwr(WbAwr), .WbDin(WbDin), .WbWrEn(WbWrEn),
        .OpA(OpA), .OpB(OpB), .Imm(Imm), .DstReg(DstReg), .Opcode(Opcode), .Func(Func),
        .OutValid(OutValid), .OutReady(OutReady)
    );

    always @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (WbWrEn && WbAwr != 5'd0) begin
            rf[WbAwr] <= WbDin;
        end
    end
    assign RfDout1 = rf[RfArd1];
    assign RfDout2 = rf[RfArd2];

    // Value a source register will hold once the concurrent write-back lands
    function automatic logic [31:0] exp_op(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return rf[a];
    endfunction

    function automatic logic [112:0] exp_dec(input logic [31:0] ins, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        logic [5:0]  opc;
        logic [31:0] imm;
        logic [4:0]  dst;
        opc = ins[31:26];
        if (opc == 6'h0C || opc == 6'h0D || opc == 6'h0E) imm = 32'(ins[15:0]);
        else if (opc == 6'h0F) imm = 32'(ins[15:0]) * 32'h10000;
        else imm = 32'($signed(ins[15:0]));
        if (opc == 6'h00) dst = ins[15:11];
        else if (opc == 6'h03) dst = 5'd31;
        else dst = ins[20:16];
        return {exp_op(ins[25:21], we, wa, wd), exp_op(ins[20:16], we, wa, wd), imm, dst, opc, ins[5:0]};
    endfunction

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        WbWrEn = 1'b1; WbAwr = a; WbDin = d;
        @(posedge Clk); #1;
        WbWrEn = 1'b0;
    endtask

    // Accept one instruction from IDLE and pass the READ edge with the given write-back
    task automatic start(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, output logic [112:0] e);
        Instr = ins; InstrValid = 1'b1; OutReady = 1'b0; WbWrEn = 1'b0;
        @(posedge Clk); #1;
        InstrValid = 1'b0; WbWrEn = we; WbAwr = wa; WbDin = wd;
        e = exp_dec(ins, we, wa, wd);
        @(posedge Clk); #1;
        WbWrEn = 1'b0;
    endtask

    task automatic drain();
        OutReady = 1'b1; InstrValid = 1'b0;
        @(posedge Clk); #1;
        OutReady = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Instr = 32'hFFFF_FFFF; InstrValid = 1'b1; OutReady = 1'b1;
        WbWrEn = 1'b0; WbAwr = 5'd0; WbDin = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (InstrReady !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", InstrReady); end
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", OutValid); end
        checks++;
        if ({OpA, OpB, Imm, DstReg, Opcode, Func, RfArd1, RfArd2} !== 123'd0) begin
            failures++; $display("FAIL reset_outputs got=%h want=0", {OpA, OpB, Imm, DstReg, Opcode, Func, RfArd1, RfArd2});
        end
        InstrValid = 1'b0; OutReady = 1'b0; Rst = 1'b0;
        #1;
        checks++; if (InstrReady !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b want=1", InstrReady); end
    endtask

    task automatic test_rtype_add();
        logic [112:0] e;
        wb_write(5'd8, 32'd5);
        wb_write(5'd9, 32'd7);
        Instr = 32'h0109_5020; InstrValid = 1'b1; OutReady = 1'b0;
        @(posedge Clk); #1;
        InstrValid = 1'b0;
        checks++; if ({InstrReady, OutValid} !== 2'b00) begin failures++; $display("FAIL add_read_cycle got=%b want=00", {InstrReady, OutValid}); end
        @(posedge Clk); #1;
        e = {32'd5, 32'd7, 32'h0000_5020, 5'd10, 6'd0, 6'h20};
        checks++; if (OutValid !== 1'b1) begin failures++; $display("FAIL add_latency got=%b want=1", OutValid); end
        checks++; if ({OpA, OpB, Imm, DstReg, Opcode, Func} !== e) begin failures++; $display("FAIL add_fields got=%h want=%h", {OpA, OpB, Imm, DstReg, Opcode, Func}, e); end
        drain();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL add_to_idle got=%b want=0", OutValid); end
    endtask

    task automatic test_immediate();
        logic [112:0] e;
        logic [31:0] ins [4];
        logic [31:0] imm_w [4];
        logic [4:0]  dst_w [4];
        ins[0] = 32'h3404_8001; imm_w[0] = 32'h0000_8001; dst_w[0] = 5'd4;
        ins[1] = 32'h2004_8001; imm_w[1] = 32'hFFFF_8001; dst_w[1] = 5'd4;
        ins[2] = 32'h3C04_1234; imm_w[2] = 32'h1234_0000; dst_w[2] = 5'd4;
        ins[3] = 32'h0C00_8010; imm_w[3] = 32'hFFFF_8010; dst_w[3] = 5'd31;
        for (int i = 0; i < 4; i++) begin
            start(ins[i], 1'b0, 5'd0, 32'd0, e);
            checks++;
            if ({Imm, DstReg, OpA} !== {imm_w[i], dst_w[i], 32'd0}) begin
                failures++; $display("FAIL imm_%0d got=%h/%0d/%h want=%h/%0d/0", i, Imm, DstReg, OpA, imm_w[i], dst_w[i]);
            end
            drain();
        end
    endtask

    task automatic test_bypass();
        logic [112:0] e;
        wb_write(5'd8, 32'h1111_1111);
        start(32'h0109_5020, 1'b1, 5'd8, 32'hDEAD_BEEF, e);
        checks++; if (OpA !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_hit got=%h want=deadbeef", OpA); end
        drain();
        start(32'h0009_5020, 1'b1, 5'd0, 32'hDEAD_BEEF, e);
        checks++; if (OpA !== 32'd0) begin failures++; $display("FAIL bypass_r0 got=%h want=0", OpA); end
        drain();
    endtask

    task automatic test_random_decode();
        logic [112:0] e;
        logic [31:0]  ins;
        logic         we;
        logic [4:0]   wa;
        for (int r = 1; r < 32; r++) wb_write(5'(r), $urandom);
        for (int i = 0; i < 24; i++) begin
            ins = $urandom;
            we = 1'($urandom_range(1));
            wa = ($urandom_range(1) == 1) ? ins[25:21] : 5'($urandom_range(31));
            start(ins, we, wa, $urandom, e);
            checks++;
            if ({OpA, OpB, Imm, DstReg, Opcode, Func} !== e) begin
                failures++; $display("FAIL rand_%0d ins=%h got=%h want=%h", i, ins, {OpA, OpB, Imm, DstReg, Opcode, Func}, e);
            end
            checks++;
            if ({RfArd1, RfArd2} !== {ins[25:21], ins[20:16]}) begin
                failures++; $display("FAIL rand_addr_%0d got=%h want=%h", i, {RfArd1, RfArd2}, {ins[25:21], ins[20:16]});
            end
            drain();
        end
    endtask

    task automatic test_stall();
        logic [112:0] e;
        logic [31:0]  b_w;
        wb_write(5'd8, 32'hA5A5_0001);
        wb_write(5'd9, 32'h0000_0009);
        start(32'h0109_5020, 1'b0, 5'd0, 32'd0, e);
        Instr = 32'h0000_0000; InstrValid = 1'b1; OutReady = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            WbWrEn = (c == 3); WbAwr = 5'd9; WbDin = 32'h1234_5678;
            #1;
            checks++; if (InstrReady !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d got=%b want=0", c, InstrReady); end
            @(posedge Clk); #1;
            WbWrEn = 1'b0;
            b_w = (c >= 3) ? 32'h1234_5678 : 32'h0000_0009;
            checks++;
            if ({OutValid, OpA, OpB, DstReg} !== {1'b1, 32'hA5A5_0001, b_w, 5'd10}) begin
                failures++; $display("FAIL stall_%0d got=%b/%h/%h/%0d want=1/a5a50001/%h/10", c, OutValid, OpA, OpB, DstReg, b_w);
            end
        end
        Instr = 32'h2004_8001; OutReady = 1'b1;
        @(posedge Clk); #1;
        InstrValid = 1'b0; OutReady = 1'b0;
        checks++; if ({OutValid, RfArd2} !== {1'b0, 5'd4}) begin failures++; $display("FAIL stall_release got=%b/%0d want=0/4", OutValid, RfArd2); end
        @(posedge Clk); #1;
        checks++; if ({OutValid, Imm} !== {1'b1, 32'hFFFF_8001}) begin failures++; $display("FAIL stall_next got=%b/%h want=1/ffff8001", OutValid, Imm); end
        drain();
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [31:0]  ins [N];
        logic [112:0] expq [$];
        logic [112:0] e;
        logic         acc;
        int           idx = 0;
        for (int i = 0; i < N; i++) ins[i] = $urandom;
        OutReady = 1'b1;
        for (int cyc = 0; cyc < 2 * N + 2; cyc++) begin
            InstrValid = (idx < N);
            Instr = ins[(idx < N) ? idx : 0];
            #1;
            acc = InstrReady && InstrValid;
            @(posedge Clk); #1;
            if (acc) begin expq.push_back(exp_dec(ins[idx], 1'b0, 5'd0, 32'd0)); idx++; end
            checks++;
            if (OutValid !== ((cyc % 2 == 1) && cyc < 2 * N)) begin
                failures++; $display("FAIL b2b_valid_cyc%0d got=%b want=%b", cyc, OutValid, (cyc % 2 == 1) && cyc < 2 * N);
            end
            if (OutValid === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                checks++;
                if ({OpA, OpB, Imm, DstReg, Opcode, Func} !== e) begin
                    failures++; $display("FAIL b2b_order_cyc%0d got=%h want=%h", cyc, {OpA, OpB, Imm, DstReg, Opcode, Func}, e);
                end
            end
        end
        checks++; if (idx !== N) begin failures++; $display("FAIL b2b_accepted got=%0d want=%0d", idx, N); end
        OutReady = 1'b0; InstrValid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [112:0] e;
        Instr = 32'h0109_5020; InstrValid = 1'b1; OutReady = 1'b0;
        @(posedge Clk); #1;
        InstrValid = 1'b0; Rst = 1'b1;
        #1;
        checks++; if ({InstrReady, OutValid} !== 2'b00) begin failures++; $display("FAIL rst_mid_during got=%b want=00", {InstrReady, OutValid}); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        #1;
        checks++;
        if ({OpA, OpB, Imm, DstReg, Opcode, Func, RfArd1, RfArd2, InstrReady, OutValid} !== {123'd0, 2'b10}) begin
            failures++; $display("FAIL rst_mid_after got=%h/%b/%b want=0/1/0", {OpA, OpB, Imm, DstReg, Opcode, Func, RfArd1, RfArd2}, InstrReady, OutValid);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_mid_quiet_%0d got=%b want=0", c, OutValid); end
        end
        start(32'h3404_8001, 1'b0, 5'd0, 32'd0, e);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge Clk); #1;
            checks++; if ({OutValid, Imm} !== 33'd0) begin failures++; $display("FAIL rst_full_quiet_%0d got=%b/%h want=0/0", c, OutValid, Imm); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype_add();
        test_immediate();
        test_bypass();
        test_random_decode();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
